// File: rtl/cmp_wb_buffer.sv
// -----------------------------------------------------------------------------
// cmp_wb_buffer
//
// Small circular FIFO that sits between a compare unit and the ROB writeback
// port. Compare results ({rob_index, result}) are queued here so that the
// compare unit can keep issuing while the ROB is busy. When the queue is full,
// the unit is stalled. Entries drain to the ROB in the order they arrived.
//
// Parameters
//   ROB_INDEX_WIDTH  width of the ROB index fields
//   DEPTH            number of entries (power of two, >= 2)
//
// Ports
//   clk              clock; all state changes on its rising edge
//   rstn             asynchronous active-low reset
//   flush            synchronous flush; empties the buffer
//   cmp_done_i       compare result valid
//   cmp_rob_index_i  ROB index of the compare result
//   cmp_result_i     compare outcome bit
//   cmp_stall_o      stall to the compare unit (buffer full)
//   wb_valid_o       writeback request to the ROB (buffer not empty)
//   wb_rob_index_o   ROB index of the head entry
//   wb_result_o      compare outcome of the head entry
//   wb_ready_i       ROB accepts the writeback this cycle
//   count_o          current occupancy
// -----------------------------------------------------------------------------
module cmp_wb_buffer #(
    parameter int ROB_INDEX_WIDTH = 6,
    parameter int DEPTH           = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush,
    input  logic                          cmp_done_i,
    input  logic [ROB_INDEX_WIDTH-1:0]    cmp_rob_index_i,
    input  logic                          cmp_result_i,
    output logic                          cmp_stall_o,
    output logic                          wb_valid_o,
    output logic [ROB_INDEX_WIDTH-1:0]    wb_rob_index_o,
    output logic                          wb_result_o,
    input  logic                          wb_ready_i,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ROB_INDEX_WIDTH + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Pointer and occupancy state
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_next;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;

    // Payload storage; never reset, only meaningful for occupied slots
    logic [ENTRY_W-1:0] entry_reg [DEPTH];
    logic [ENTRY_W-1:0] head_entry;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);

    // The stall is taken from the registered count only, so a pop in the same
    // cycle cannot free a slot for a push: a full buffer rejects the push even
    // while it drains. An upstream result held under stall is therefore taken
    // exactly once, in the first cycle after the count drops below DEPTH.
    assign push = cmp_done_i && !full && !flush;
    assign pop  = !empty && wb_ready_i && !flush;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;

        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            // DEPTH is a power of two, so plain pointer overflow is the wrap
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Control state registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Payload write
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            entry_reg[wr_ptr_reg] <= {cmp_rob_index_i, cmp_result_i};
        end
    end

    // The head is read straight from the array, so a result pushed at one edge
    // becomes visible right after that edge and never in the same cycle.
    assign head_entry = entry_reg[rd_ptr_reg];

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cmp_stall_o = full;
    assign wb_valid_o  = !empty;
    assign count_o     = count_reg;

    // Payload is masked while invalid so that stale or uninitialised slots
    // never leak onto the writeback bus, including during reset.
    assign wb_rob_index_o = wb_valid_o ? head_entry[ENTRY_W-1:1] : '0;
    assign wb_result_o    = wb_valid_o ? head_entry[0]           : 1'b0;

endmodule

// File: tb/tb_cmp_wb_buffer.sv
module tb_cmp_wb_buffer;

    localparam int W = 6;
    localparam int D = 4;

    typedef logic [W:0] entry_t;

    logic           clk;
    logic           rstn;
    logic           flush;
    logic           cmp_done_i;
    logic [W-1:0]   cmp_rob_index_i;
    logic           cmp_result_i;
    logic           cmp_stall_o;
    logic           wb_valid_o;
    logic [W-1:0]   wb_rob_index_o;
    logic           wb_result_o;
    logic           wb_ready_i;
    logic [2:0]     count_o;

    int checks = 0;
    int errors = 0;

    // Reference model: the buffer contents as an ordered queue
    entry_t q[$];

    cmp_wb_buffer #(
        .ROB_INDEX_WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .flush(flush),
        .cmp_done_i(cmp_done_i),
        .cmp_rob_index_i(cmp_rob_index_i),
        .cmp_result_i(cmp_result_i),
        .cmp_stall_o(cmp_stall_o),
        .wb_valid_o(wb_valid_o),
        .wb_rob_index_o(wb_rob_index_o),
        .wb_result_o(wb_result_o),
        .wb_ready_i(wb_ready_i),
        .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    // Compare every output against what the queue model says it should be
    task automatic check_outputs(input string tag);
        logic [31:0] exp_valid;
        logic [31:0] exp_stall;
        logic [31:0] exp_count;
        logic [31:0] exp_idx;
        logic [31:0] exp_res;
        exp_valid = (q.size() != 0) ? 32'd1 : 32'd0;
        exp_stall = (q.size() == D) ? 32'd1 : 32'd0;
        exp_count = 32'(q.size());
        exp_idx   = (q.size() != 0) ? 32'(q[0][W:1]) : 32'd0;
        exp_res   = (q.size() != 0) ? 32'(q[0][0])   : 32'd0;
        chk({tag, ".valid"}, 32'(wb_valid_o),     exp_valid);
        chk({tag, ".stall"}, 32'(cmp_stall_o),    exp_stall);
        chk({tag, ".count"}, 32'(count_o),        exp_count);
        chk({tag, ".idx"},   32'(wb_rob_index_o), exp_idx);
        chk({tag, ".res"},   32'(wb_result_o),    exp_res);
    endtask

    // Apply one clock edge to the model; uses the pre-edge occupancy for both
    // the accept and the pop decision.
    task automatic model_edge(input logic d, input logic [W-1:0] i, input logic r,
                              input logic rdy, input logic fl, output logic acc);
        bit do_pop;
        bit do_push;
        acc = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            do_pop  = (q.size() != 0) && rdy;
            do_push = d && (q.size() != D);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back({i, r});
            acc = do_push;
        end
    endtask

    // One cycle: drive inputs, check outputs at the falling edge, step model
    task automatic cyc(input string tag, input logic d, input logic [W-1:0] i, input logic r,
                       input logic rdy, input logic fl, output logic acc);
        cmp_done_i      = d;
        cmp_rob_index_i = i;
        cmp_result_i    = r;
        wb_ready_i      = rdy;
        flush           = fl;
        @(negedge clk);
        check_outputs(tag);
        $display("cyc %s done=%0b idx=%0d res=%0b rdy=%0b flush=%0b | valid=%0b wb_idx=%0d count=%0d stall=%0b",
                 tag, d, i, r, rdy, fl, wb_valid_o, wb_rob_index_o, count_o, cmp_stall_o);
        @(posedge clk);
        model_edge(d, i, r, rdy, fl, acc);
        #1;
    endtask

    initial begin
        logic acc;
        logic pend;
        logic [W-1:0] pidx;
        logic pres;
        logic rdy;
        logic fl;

        rstn = 1'b0;
        flush = 1'b0;
        cmp_done_i = 1'b0;
        cmp_rob_index_i = '0;
        cmp_result_i = 1'b0;
        wb_ready_i = 1'b0;

        // Reset state, before and across clock edges
        #2;
        check_outputs("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset_held");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single result, one-cycle latency
        cyc("single_push", 1'b1, 6'd5, 1'b1, 1'b1, 1'b0, acc);
        chk("single_acc", 32'(acc), 32'd1);
        chk("single_valid", 32'(wb_valid_o), 32'd1);
        chk("single_idx", 32'(wb_rob_index_o), 32'd5);
        chk("single_res", 32'(wb_result_o), 32'd1);
        cyc("single_pop", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, acc);
        chk("single_drained", 32'(count_o), 32'd0);

        // Fill to full with the ROB stalled
        for (int k = 1; k <= 4; k++) begin
            cyc("fill", 1'b1, W'(k), k[0], 1'b0, 1'b0, acc);
        end
        chk("fill_count", 32'(count_o), 32'd4);
        chk("fill_stall", 32'(cmp_stall_o), 32'd1);
        // Held result under stall is not stored
        repeat (2) begin
            cyc("held", 1'b1, 6'd5, 1'b1, 1'b0, 1'b0, acc);
            chk("held_rejected", 32'(acc), 32'd0);
        end
        // Full with concurrent pop: pop happens, push rejected
        cyc("full_pop", 1'b1, 6'd5, 1'b1, 1'b1, 1'b0, acc);
        chk("full_pop_rejected", 32'(acc), 32'd0);
        chk("full_pop_count", 32'(count_o), 32'd3);
        // Next cycle the held result goes in, exactly once
        cyc("held_accept", 1'b1, 6'd5, 1'b1, 1'b1, 1'b0, acc);
        chk("held_accepted", 32'(acc), 32'd1);
        repeat (5) cyc("drain", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, acc);
        chk("drain_empty", 32'(count_o), 32'd0);

        // Streaming with pointer wrap
        for (int k = 0; k < 10; k++) begin
            cyc("stream", 1'b1, W'(k), k[0], 1'b1, 1'b0, acc);
            chk("stream_le1", (count_o <= 3'd1) ? 32'd1 : 32'd0, 32'd1);
        end
        cyc("stream_tail", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, acc);

        // Flush with a concurrent result
        for (int k = 0; k < 3; k++) cyc("pre_flush", 1'b1, W'(20 + k), 1'b0, 1'b0, 1'b0, acc);
        chk("pre_flush_count", 32'(count_o), 32'd3);
        cyc("flush", 1'b1, 6'd9, 1'b1, 1'b0, 1'b1, acc);
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_valid", 32'(wb_valid_o), 32'd0);
        chk("flush_dropped", 32'(acc), 32'd0);
        cyc("post_flush", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, acc);

        // Reset mid-operation, asserted between edges
        cyc("pre_rst", 1'b1, 6'd30, 1'b1, 1'b0, 1'b0, acc);
        cyc("pre_rst", 1'b1, 6'd31, 1'b0, 1'b0, 1'b0, acc);
        chk("pre_rst_count", 32'(count_o), 32'd2);
        cmp_done_i = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        q.delete();
        check_outputs("rst_mid");
        @(posedge clk);
        #1;
        check_outputs("rst_mid_held");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        cyc("post_rst", 1'b1, 6'd7, 1'b0, 1'b1, 1'b0, acc);
        chk("post_rst_idx", 32'(wb_rob_index_o), 32'd7);
        chk("post_rst_count", 32'(count_o), 32'd1);

        // Randomized traffic: the compare unit holds a result until accepted
        pend = 1'b0;
        pidx = '0;
        pres = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pidx = W'($urandom);
                pres = 1'($urandom);
            end
            if (n < 200) rdy = ($urandom_range(0, 2) == 0);
            else         rdy = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 49) == 0);
            cyc("rand", pend, pidx, pres, rdy, fl, acc);
            if (acc || fl) pend = 1'b0;
        end
        repeat (6) cyc("final_drain", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, acc);
        chk("final_empty", 32'(count_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_wb_buffer.md
CMP_WB_BUFFER -- requirements
Module: cmp_wb_buffer

Interface
REQ-001 SHALL have parameter ROB_INDEX_WIDTH, default 6, width of ROB index fields.
REQ-002 SHALL have parameter DEPTH, default 4, number of buffer entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-006 SHALL have port cmp_done_i  input  1  compare unit result valid.
REQ-007 SHALL have port cmp_rob_index_i  input  ROB_INDEX_WIDTH  ROB index of the compare result.
REQ-008 SHALL have port cmp_result_i  input  1  compare outcome bit.
REQ-009 SHALL have port cmp_stall_o  output  1  backpressure to the compare unit's stall input.
REQ-010 SHALL have port wb_valid_o  output  1  writeback request to the ROB.
REQ-011 SHALL have port wb_rob_index_o  output  ROB_INDEX_WIDTH  ROB index being written back.
REQ-012 SHALL have port wb_result_o  output  1  compare outcome being written back.
REQ-013 SHALL have port wb_ready_i  input  1  ROB accepts the writeback this cycle.
REQ-014 SHALL have port count_o  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL store entries {rob_index, result} in a DEPTH-entry circular FIFO with read pointer, write pointer and occupancy count.
REQ-016 SHALL drive cmp_stall_o = (count == DEPTH), combinationally from registered state.
REQ-017 SHALL push when cmp_done_i && !cmp_stall_o && !flush.
REQ-018 SHALL treat cmp_done_i held high under stall as one pending result, accepted once, in the first cycle cmp_stall_o is low.
REQ-019 SHALL drive wb_valid_o = (count != 0), with wb_rob_index_o/wb_result_o equal to the head entry.
REQ-020 SHALL pop when wb_valid_o && wb_ready_i && !flush.
REQ-021 SHALL hold wb_valid_o and the head entry stable while wb_ready_i is low.
REQ-022 SHALL have no bypass: a result pushed at edge N appears on wb_valid_o after edge N, at earliest; latency is one cycle.
REQ-023 SHALL, on simultaneous push and pop when not full, keep count unchanged and advance both pointers.
REQ-024 SHALL reject a push when full, even if a pop occurs in the same cycle; cmp_stall_o stays high that cycle.
REQ-025 SHALL wrap both pointers modulo DEPTH.
REQ-026 SHALL deliver entries in push order; no reordering, duplication or loss.
REQ-027 SHALL, when flush is high at an edge, set count, read pointer and write pointer to 0 and ignore push/pop that cycle; wb_valid_o and cmp_stall_o are low after the edge.
REQ-028 SHALL ignore wb_ready_i when wb_valid_o is low.
REQ-029 SHALL ignore entry payloads when not valid; payload registers need not be cleared.

Reset
REQ-030 SHALL, while rstn is low and independent of clk, force count, read pointer and write pointer to 0.
REQ-031 SHALL, during and after reset, hold outputs at wb_valid_o=0, cmp_stall_o=0, count_o=0; wb_rob_index_o and wb_result_o are 0.
REQ-032 SHALL discard all entries on reset asserted mid-operation; first push after rstn rises behaves as into an empty buffer.

Verification
REQ-033 SHALL cover the single-result case: push {idx=5, res=1} at edge 0, wb_ready_i=1 -> wb_valid_o=1 with idx 5, res 1 during cycle 1; count returns to 0 after edge 1.
REQ-034 SHALL cover fill and stall: wb_ready_i=0, push idx 1,2,3,4 -> count_o=4, cmp_stall_o=1; a held done with idx 5 is not stored; raise wb_ready_i -> pops 1..4 in order, then idx 5 accepted once.
REQ-035 SHALL cover full with concurrent pop: count=4, wb_ready_i=1, cmp_done_i=1 -> pop occurs, push is rejected, count_o=3.
REQ-036 SHALL cover streaming and wrap: 10 back-to-back pushes idx 0..9 with wb_ready_i=1 -> wb outputs 0..9 in order, one per cycle, count_o never exceeds 1, pointers wrap twice.
REQ-037 SHALL cover flush: count=3, then flush=1 with cmp_done_i=1 -> count_o=0 and wb_valid_o=0 after the edge, and the concurrent result is dropped.
REQ-038 SHALL cover reset mid-operation: count=2, rstn driven low between edges -> outputs clear immediately, with no clock edge needed.
